// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the data-RAM arbiter: arbiter state encodings,
// default data/address widths and the lock-hold limit used when the
// MEM_ARB_LOCK_EN build option is enabled.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    // Default data-path widths of the shared data RAM
    localparam int ARB_DATA_W      = 32;
    localparam int ARB_DATA_ADDR_W = 16;

    // Arbiter FSM states
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_e;

    // Maximum consecutive grants a locking core may hold
    localparam int LOCK_MAX   = 16;
    localparam int LOCK_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Starting at last_grant+1 and
// wrapping modulo NUM_CORES, returns the index of the first asserted request.
// Ports:
//   req        in   NUM_CORES   request vector
//   last_grant in   CORE_ID_W   most recently granted index
//   grant      out  CORE_ID_W   selected index (0 when nothing requests)
//   valid      out  1           at least one request present
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter  int NUM_CORES = 4,
    localparam int CORE_ID_W = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [CORE_ID_W-1:0] last_grant,
    output logic [CORE_ID_W-1:0] grant,
    output logic                 valid
);

    // Walk the cores once, beginning just after the last winner; the first
    // hit wins and later hits are ignored via the valid flag.
    always_comb begin
        int                   cand;
        logic [CORE_ID_W-1:0] cand_idx;
        grant    = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            cand_idx = CORE_ID_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                grant = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single data-RAM port between the MM stages of NUM_CORES cores.
// Round-robin arbitration; each access is a req/ready handshake with the RAM.
// A per-core core_wait stalls cores that lose arbitration or are in flight.
//
// Build option: MEM_ARB_LOCK_EN adds the core_lock input. A granted core that
// holds core_lock on its completing cycle and still requests on the next
// IDLE cycle is re-granted (atomic read-modify-write), bounded to LOCK_MAX
// consecutive grants.
//
// Ports:
//   clk         in   1                      clock, posedge
//   rst_n       in   1                      synchronous reset, active-low
//   core_read   in   NUM_CORES              per-core load request
//   core_write  in   NUM_CORES              per-core store request
//   core_lock   in   NUM_CORES              lock request (MEM_ARB_LOCK_EN only)
//   core_addr   in   NUM_CORES*DATA_ADDR_W  packed addresses, core i at [i*W +: W]
//   core_wdata  in   NUM_CORES*DATA_W       packed store data
//   core_rdata  out  DATA_W                 load data, broadcast to all cores
//   core_wait   out  NUM_CORES              1 = core must stall and hold request
//   ram_req     out  1                      access request to RAM
//   ram_we      out  1                      1 = write, 0 = read
//   ram_addr    out  DATA_ADDR_W            RAM address
//   ram_wdata   out  DATA_W                 RAM write data
//   ram_rdata   in   DATA_W                 RAM read data, valid with ram_ready
//   ram_ready   in   1                      access completes this cycle
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int DATA_ADDR_W = ARB_DATA_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CORES-1:0]             core_read,
    input  logic [NUM_CORES-1:0]             core_write,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]             core_lock,
`endif
    input  logic [NUM_CORES*DATA_ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]      core_wdata,
    output logic [DATA_W-1:0]                core_rdata,
    output logic [NUM_CORES-1:0]             core_wait,
    output logic                             ram_req,
    output logic                             ram_we,
    output logic [DATA_ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]                ram_wdata,
    input  logic [DATA_W-1:0]                ram_rdata,
    input  logic                             ram_ready
);

    localparam int CORE_ID_W = $clog2(NUM_CORES);

    arb_state_e             state, state_nxt;
    logic [CORE_ID_W-1:0]   grant, grant_nxt;
    logic [CORE_ID_W-1:0]   last_grant, last_grant_nxt;
    logic [DATA_ADDR_W-1:0] lat_addr, lat_addr_nxt;
    logic                   lat_we, lat_we_nxt;
    logic [DATA_W-1:0]      lat_wdata, lat_wdata_nxt;

`ifdef MEM_ARB_LOCK_EN
    logic                   lock_pending, lock_pending_nxt;
    logic [LOCK_CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
`endif

    logic [NUM_CORES-1:0]   request;
    logic [CORE_ID_W-1:0]   pick_idx;
    logic                   pick_valid;
    logic                   access_done;

    assign request     = core_read | core_write;
    assign access_done = (state == ARB_ACCESS) && ram_ready;

    rr_picker #(
        .NUM_CORES (NUM_CORES)
    ) u_picker (
        .req        (request),
        .last_grant (last_grant),
        .grant      (pick_idx),
        .valid      (pick_valid)
    );

    // RAM side is driven purely from the latched copy, so address, direction
    // and data stay stable for the whole ACCESS regardless of core activity.
    assign ram_req    = (state == ARB_ACCESS);
    assign ram_we     = lat_we;
    assign ram_addr   = lat_addr;
    assign ram_wdata  = lat_wdata;
    assign core_rdata = ram_rdata;

    // Every requesting core stalls except the granted one on its completing
    // cycle. A core that dropped its request mid-access sees no wait at all.
    // While reset is asserted nothing completes, so wait simply follows request.
    always_comb begin
        core_wait = request;
        if (rst_n && access_done) begin
            core_wait[grant] = 1'b0;
        end
    end

    // State and latched-access registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= CORE_ID_W'(NUM_CORES - 1);
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_pending <= 1'b0;
            lock_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            lat_addr   <= lat_addr_nxt;
            lat_we     <= lat_we_nxt;
            lat_wdata  <= lat_wdata_nxt;
`ifdef MEM_ARB_LOCK_EN
            lock_pending <= lock_pending_nxt;
            lock_cnt     <= lock_cnt_nxt;
`endif
        end
    end

    // Next-state logic. In IDLE the winner's request is captured and the FSM
    // moves to ACCESS; in ACCESS it waits for ram_ready, never aborting the RAM
    // even if the owning core has gone away.
    always_comb begin
        logic [CORE_ID_W-1:0] sel;
        logic                 take;
        logic                 relock;

        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        lat_addr_nxt   = lat_addr;
        lat_we_nxt     = lat_we;
        lat_wdata_nxt  = lat_wdata;
        sel            = pick_idx;
        take           = 1'b0;
        relock         = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        lock_pending_nxt = lock_pending;
        lock_cnt_nxt     = lock_cnt;
`endif

        case (state)
            ARB_IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                // A locked owner that still requests keeps the port, unless it
                // has already used up its run of consecutive grants.
                if (lock_pending && request[grant] &&
                    (lock_cnt != LOCK_CNT_W'(LOCK_MAX - 1))) begin
                    sel    = grant;
                    take   = 1'b1;
                    relock = 1'b1;
                end else if (pick_valid) begin
                    sel  = pick_idx;
                    take = 1'b1;
                end
                lock_pending_nxt = 1'b0;
                lock_cnt_nxt     = relock ? (lock_cnt + LOCK_CNT_W'(1)) : '0;
`else
                if (pick_valid) begin
                    sel  = pick_idx;
                    take = 1'b1;
                end
`endif
                if (take) begin
                    state_nxt     = ARB_ACCESS;
                    grant_nxt     = sel;
                    lat_addr_nxt  = core_addr[int'(sel)*DATA_ADDR_W +: DATA_ADDR_W];
                    lat_wdata_nxt = core_wdata[int'(sel)*DATA_W +: DATA_W];
                    lat_we_nxt    = core_write[sel];
                    if (!relock) begin
                        last_grant_nxt = sel;
                    end
                end
            end

            ARB_ACCESS: begin
                if (ram_ready) begin
                    state_nxt = ARB_IDLE;
`ifdef MEM_ARB_LOCK_EN
                    lock_pending_nxt = core_lock[grant];
                    if (!core_lock[grant]) begin
                        lock_cnt_nxt = '0;
                    end
`endif
                end
            end

            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter with a small RAM model whose ready
// latency is programmable. Inputs change on the falling edge and outputs
// are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int AW = 16;

    logic               clk;
    logic               rst_n;
    logic [NC-1:0]      core_read;
    logic [NC-1:0]      core_write;
    logic [NC-1:0]      core_lock;
    logic [NC*AW-1:0]   core_addr;
    logic [NC*DW-1:0]   core_wdata;
    logic [DW-1:0]      core_rdata;
    logic [NC-1:0]      core_wait;
    logic               ram_req;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic [DW-1:0]      ram_rdata;
    logic               ram_ready;

    int                 n_cmp;
    int                 n_bad;
    int                 lat;
    int                 acc_cnt;
    logic [NC-1:0]      pending;
    logic [AW-1:0]      wr_addr_q[$];
    logic [DW-1:0]      wr_data_q[$];

    mem_arbiter #(
        .NUM_CORES   (NC),
        .DATA_W      (DW),
        .DATA_ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_read  (core_read),
        .core_write (core_write),
`ifdef MEM_ARB_LOCK_EN
        .core_lock  (core_lock),
`endif
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_wait  (core_wait),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: ready on the lat-th cycle of a request; completed writes logged
    assign ram_ready = ram_req && (acc_cnt == lat - 1);

    always @(posedge clk) begin
        if (ram_req && !ram_ready) begin
            acc_cnt <= acc_cnt + 1;
        end else begin
            acc_cnt <= 0;
        end
        if (ram_req && ram_ready && ram_we) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_wdata);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NC-1:0] rd, input logic [NC-1:0] wr);
        core_read  = rd;
        core_write = wr;
    endtask

    task automatic setCore(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_addr[i*AW +: AW]  = a;
        core_wdata[i*DW +: DW] = d;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus('0, '0);
        core_lock = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        lat        = 1;
        acc_cnt    = 0;
        rst_n      = 1'b0;
        core_read  = '0;
        core_write = '0;
        core_lock  = '0;
        core_addr  = '0;
        core_wdata = '0;
        ram_rdata  = '0;
        pending    = '0;

        // Reset state
        doReset();
        #1;
        checkOutput("rst_req",   ram_req,   0);
        checkOutput("rst_we",    ram_we,    0);
        checkOutput("rst_addr",  ram_addr,  0);
        checkOutput("rst_wdata", ram_wdata, 0);
        checkOutput("rst_wait",  core_wait, 0);

        // Test 1: single core 2 read, RAM ready on 3rd access cycle
        lat       = 3;
        ram_rdata = 32'hCAFE;
        setCore(2, 16'h10, 32'h0);
        applyStimulus(4'b0100, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) setCore(2, 16'h99, 32'h0);
            #1;
            checkOutput("t1_wait", core_wait, (k < 3) ? 4'b0100 : 4'b0000);
            if (k == 0) checkOutput("t1_idle_req", ram_req, 0);
            if (k >= 1) checkOutput("t1_addr", ram_addr, 16'h10);
            if (k == 1) checkOutput("t1_we", ram_we, 0);
            if (k == 3) checkOutput("t1_rdata", core_rdata, 32'hCAFE);
            @(negedge clk);
        end
        applyStimulus('0, '0);

        // Test 2: four concurrent writes, immediate ready, grants 0..3
        doReset();
        lat = 1;
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < NC; i++) setCore(i, AW'(16'h20 + i), DW'(32'h1000 + i));
        pending = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, pending);
            #1;
            checkOutput("t2_idle_wait", core_wait, pending);
            checkOutput("t2_idle_req",  ram_req,   0);
            @(negedge clk);
            #1;
            checkOutput("t2_addr",  ram_addr,  32'h20 + k);
            checkOutput("t2_wdata", ram_wdata, 32'h1000 + k);
            checkOutput("t2_we",    ram_we,    1);
            checkOutput("t2_wait",  core_wait, pending & ~(4'b0001 << k));
            pending = pending & ~(4'b0001 << k);
            @(negedge clk);
        end
        applyStimulus('0, '0);
        checkOutput("t2_nwrites", wr_addr_q.size(), 4);
        for (int i = 0; i < wr_data_q.size(); i++) begin
            checkOutput("t2_log_addr", wr_addr_q[i], 32'h20 + i);
            checkOutput("t2_log_data", wr_data_q[i], 32'h1000 + i);
        end

        // Test 3: fairness between cores 0 and 3
        doReset();
        lat = 1;
        setCore(0, 16'h30, 32'h0);
        setCore(3, 16'h33, 32'h0);
        applyStimulus(4'b1001, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("t3_idle_req", ram_req, 0);
            @(negedge clk);
            #1;
            checkOutput("t3_addr", ram_addr,  (k % 2 == 0) ? 16'h30 : 16'h33);
            checkOutput("t3_wait", core_wait, (k % 2 == 0) ? 4'b1000 : 4'b0001);
            @(negedge clk);
        end
        applyStimulus('0, '0);

        // Test 4: core 1 drops its write mid-access
        doReset();
        lat       = 3;
        ram_rdata = 32'h1234;
        wr_addr_q.delete();
        wr_data_q.delete();
        setCore(1, 16'h41, 32'hBEEF);
        setCore(2, 16'h42, 32'h0);
        applyStimulus(4'b0100, 4'b0010);
        #1;
        checkOutput("t4_c0_wait", core_wait, 4'b0110);
        @(negedge clk);
        #1;
        checkOutput("t4_c1_addr", ram_addr, 16'h41);
        checkOutput("t4_c1_we",   ram_we,   1);
        @(negedge clk);
        applyStimulus(4'b0100, 4'b0000);
        setCore(1, 16'h77, 32'hDEAD);
        #1;
        checkOutput("t4_c2_wait",  core_wait, 4'b0100);
        checkOutput("t4_c2_addr",  ram_addr,  16'h41);
        checkOutput("t4_c2_wdata", ram_wdata, 32'hBEEF);
        @(negedge clk);
        #1;
        checkOutput("t4_c3_req",  ram_req,   1);
        checkOutput("t4_c3_wait", core_wait, 4'b0100);
        @(negedge clk);
        #1;
        checkOutput("t4_c4_req",   ram_req,          0);
        checkOutput("t4_nwrites",  wr_addr_q.size(), 1);
        if (wr_data_q.size() > 0) begin
            checkOutput("t4_log_addr", wr_addr_q[0], 16'h41);
            checkOutput("t4_log_data", wr_data_q[0], 32'hBEEF);
        end
        @(negedge clk);
        #1;
        checkOutput("t4_c5_addr", ram_addr, 16'h42);
        checkOutput("t4_c5_we",   ram_we,   0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("t4_c7_wait",  core_wait,  4'b0000);
        checkOutput("t4_c7_rdata", core_rdata, 32'h1234);
        @(negedge clk);
        applyStimulus('0, '0);

        // Test 5: reset in the middle of an access
        lat = 10;
        setCore(0, 16'h50, 32'h0);
        setCore(1, 16'h51, 32'h0);
        applyStimulus(4'b0011, 4'b0000);
        #1;
        checkOutput("t5_c0_wait", core_wait, 4'b0011);
        @(negedge clk);
        #1;
        checkOutput("t5_c1_req",  ram_req,  1);
        checkOutput("t5_c1_addr", ram_addr, 16'h50);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_wait", core_wait, 4'b0011);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t5_post_req",   ram_req,   0);
        checkOutput("t5_post_addr",  ram_addr,  0);
        checkOutput("t5_post_we",    ram_we,    0);
        checkOutput("t5_post_wdata", ram_wdata, 0);
        checkOutput("t5_post_wait",  core_wait, 4'b0011);
        @(negedge clk);
        #1;
        checkOutput("t5_regrant_req",  ram_req,  1);
        checkOutput("t5_regrant_addr", ram_addr, 16'h50);
        @(negedge clk);
        applyStimulus('0, '0);

`ifdef MEM_ARB_LOCK_EN
        // Test 6: locked core 1 holds the port for 16 grants, then core 2
        doReset();
        lat = 1;
        setCore(1, 16'h61, 32'h5555);
        setCore(2, 16'h62, 32'h0);
        core_lock = 4'b0010;
        applyStimulus(4'b0100, 4'b0010);
        for (int g = 0; g < 17; g++) begin
            #1;
            checkOutput("t6_idle_req", ram_req, 0);
            @(negedge clk);
            #1;
            checkOutput("t6_addr", ram_addr, (g < 16) ? 16'h61 : 16'h62);
            @(negedge clk);
        end
        applyStimulus('0, '0);
        core_lock = '0;
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
